// File: rtl/pa_ram_loader.sv
// pa_ram_loader: write sequencer for the 16-bank packed-activation/weight RAM.
// Accepts a valid/ready stream of words and issues one registered RAM write
// per accepted word, filling bank 0 first, then bank 1, and so on.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, begins a load with cfg_* values
//   abort                 cancels a load in progress (no done pulse)
//   cfg_words_per_bank    words per bank, 1..512
//   cfg_num_banks         banks to fill, 1..16
//   in_valid/in_data      stream input
//   in_ready              high while loading (decoded from state only)
//   ram_addr/data/we      registered RAM write port, addr = {bank, word}
//   busy                  high in LOAD
//   done                  one-cycle pulse at load completion
//   cfg_err               sticky, set when a load starts with a zero config field
module pa_ram_loader #(
  parameter int unsigned BANK_BITS  = 4,
  parameter int unsigned WORD_BITS  = 9,
  parameter int unsigned ADDR_WIDTH = BANK_BITS + WORD_BITS,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_BITS:0]    cfg_words_per_bank,
  input  logic [BANK_BITS:0]    cfg_num_banks,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int unsigned WPB_W = WORD_BITS + 1;
  localparam int unsigned NB_W  = BANK_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WPB_W-1:0]      r_wpb, w_wpb_nxt;
  logic [NB_W-1:0]       r_nb, w_nb_nxt;
  logic [WORD_BITS-1:0]  r_word, w_word_nxt;
  logic [BANK_BITS-1:0]  r_bank, w_bank_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_we, w_we_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;

  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_last_bank;

  // Ready depends on state only so upstream never sees a valid->ready path.
  assign in_ready = (r_state == S_LOAD);
  assign w_accept = in_valid && (r_state == S_LOAD);

  // Zero-extended word index compared against the 10-bit latched count so
  // wpb=512 terminates at word 511 without overflow.
  assign w_last_word = ({1'b0, r_word} == (r_wpb - WPB_W'(1)));
  assign w_last_bank = ({1'b0, r_bank} == (r_nb - NB_W'(1)));

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wpb     <= '0;
      r_nb      <= '0;
      r_word    <= '0;
      r_bank    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wpb     <= w_wpb_nxt;
      r_nb      <= w_nb_nxt;
      r_word    <= w_word_nxt;
      r_bank    <= w_bank_nxt;
      r_addr    <= w_addr_nxt;
      r_data    <= w_data_nxt;
      r_we      <= w_we_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_wpb_nxt     = r_wpb;
    w_nb_nxt      = r_nb;
    w_word_nxt    = r_word;
    w_bank_nxt    = r_bank;
    w_addr_nxt    = r_addr;
    w_data_nxt    = r_data;
    w_we_nxt      = 1'b0;
    w_cfg_err_nxt = r_cfg_err;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((cfg_words_per_bank != '0) && (cfg_num_banks != '0)) begin
            w_wpb_nxt     = cfg_words_per_bank;
            w_nb_nxt      = cfg_num_banks;
            w_word_nxt    = '0;
            w_bank_nxt    = '0;
            w_cfg_err_nxt = 1'b0;
            w_state_nxt   = S_LOAD;
          end else begin
            w_cfg_err_nxt = 1'b1;
            w_state_nxt   = S_FIN;
          end
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = {r_bank, r_word};
          w_data_nxt = in_data;
          if (w_last_word) begin
            w_word_nxt = '0;
            // Bank holds on the final word so it never wraps to 0.
            if (w_last_bank) begin
              w_state_nxt = S_FIN;
            end else begin
              w_bank_nxt = r_bank + BANK_BITS'(1);
            end
          end else begin
            w_word_nxt = r_word + WORD_BITS'(1);
          end
        end
        // Abort overrides completion; an accepted word is still written.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_word_nxt  = '0;
          w_bank_nxt  = '0;
        end
      end

      S_FIN: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_LOAD);
    w_done_nxt = (w_state_nxt == S_FIN);
  end

  assign ram_addr = r_addr;
  assign ram_data = r_data;
  assign ram_we   = r_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_pa_ram_loader.sv
// Directed self-checking bench for pa_ram_loader.
module tb_pa_ram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [9:0]  cfg_words_per_bank;
  logic [4:0]  cfg_num_banks;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [12:0] ram_addr;
  logic [31:0] ram_data;
  logic        ram_we;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [12:0] q_addr[$];
  logic [31:0] q_data[$];
  int          done_cnt   = 0;
  int          done_no_we = 0;

  pa_ram_loader dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .abort              (abort),
    .cfg_words_per_bank (cfg_words_per_bank),
    .cfg_num_banks      (cfg_num_banks),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .ram_addr           (ram_addr),
    .ram_data           (ram_data),
    .ram_we             (ram_we),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/done monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        q_addr.push_back(ram_addr);
        q_data.push_back(ram_data);
      end
      if (done) begin
        done_cnt++;
        if (!ram_we) done_no_we++;
      end
    end
  end

  task automatic clear_mon();
    q_addr.delete();
    q_data.delete();
    done_cnt   = 0;
    done_no_we = 0;
  endtask

  // Pulses start for one cycle; returns on the negedge after start was sampled.
  task automatic start_load(input logic [9:0] wpb, input logic [4:0] nb);
    @(negedge clk);
    cfg_words_per_bank = wpb;
    cfg_num_banks      = nb;
    start              = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one word; returns on the negedge where its write is visible.
  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", ram_we); end
    n_tests++; if (ram_addr !== 13'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", ram_addr); end
    n_tests++; if (ram_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", ram_data); end
    n_tests++; if ({busy, done, cfg_err, in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done, cfg_err, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [12:0] exp_addr [8];
    exp_addr = '{13'h0000, 13'h0001, 13'h0002, 13'h0003,
                 13'h0200, 13'h0201, 13'h0202, 13'h0203};
    clear_mon();
    start_load(10'd4, 5'd2);
    // Config changes after start must be ignored.
    cfg_words_per_bank = 10'd1;
    cfg_num_banks      = 5'd1;
    n_tests++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy got busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    for (int i = 0; i < 8; i++) feed(32'hA0 + 32'(i));
    in_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || done !== 1'b1) begin
      n_fail++; $display("FAIL basic_last got we=%b done=%b want 1 1", ram_we, done);
    end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop got %b want 0", in_ready); end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle got busy=%b done=%b want 0 0", busy, done);
    end
    n_tests++; if (q_addr.size() != 8) begin n_fail++; $display("FAIL basic_count got %0d want 8", q_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < q_addr.size()) begin
        n_tests++; if (q_addr[i] !== exp_addr[i] || q_data[i] !== 32'hA0 + 32'(i)) begin
          n_fail++; $display("FAIL basic_write%0d got %h/%h want %h/%h", i, q_addr[i], q_data[i], exp_addr[i], 32'hA0 + 32'(i));
        end
      end
    end
    n_tests++; if (done_cnt != 1 || done_no_we != 0) begin
      n_fail++; $display("FAIL basic_done got cnt=%0d no_we=%0d want 1 0", done_cnt, done_no_we);
    end
  endtask

  task automatic test_gaps();
    logic [5:0] vpat;
    int         j;
    vpat = 6'b101001;  // bit k = in_valid in cycle k: 1,0,0,1,0,1
    j = 0;
    clear_mon();
    start_load(10'd3, 5'd1);
    for (int k = 0; k < 6; k++) begin
      in_valid = vpat[k];
      in_data  = 32'hD0 + 32'(k);
      @(negedge clk);
      n_tests++; if (ram_we !== vpat[k]) begin
        n_fail++; $display("FAIL gaps_we%0d got %b want %b", k, ram_we, vpat[k]);
      end
      if (vpat[k]) begin
        n_tests++; if (ram_addr !== 13'(j) || ram_data !== 32'hD0 + 32'(k)) begin
          n_fail++; $display("FAIL gaps_wr%0d got %h/%h want %h/%h", k, ram_addr, ram_data, 13'(j), 32'hD0 + 32'(k));
        end
        j++;
      end
    end
    in_valid = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL gaps_done got %b want 1", done); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_zero_cfg();
    clear_mon();
    start_load(10'd0, 5'd3);
    n_tests++; if (cfg_err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zcfg_fin got err=%b done=%b busy=%b want 1 1 0", cfg_err, done, busy);
    end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL zcfg_after got done=%b err=%b want 0 1", done, cfg_err);
    end
    n_tests++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL zcfg_nowrite got %0d want 0", q_addr.size()); end
    start_load(10'd1, 5'd1);
    n_tests++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL zcfg_clear got %b want 0", cfg_err); end
    feed(32'h55);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_abort();
    clear_mon();
    start_load(10'd8, 5'd2);
    for (int k = 0; k < 5; k++) begin
      abort = (k == 4);
      feed(32'hB0 + 32'(k));
    end
    abort    = 1'b0;
    in_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 13'h4) begin
      n_fail++; $display("FAIL abort_lastwr got we=%b addr=%h want 1 0004", ram_we, ram_addr);
    end
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_state got busy=%b rdy=%b done=%b want 0 0 0", busy, in_ready, done);
    end
    @(negedge clk);
    n_tests++; if (ram_we !== 1'b0 || q_addr.size() != 5) begin
      n_fail++; $display("FAIL abort_count got we=%b n=%0d want 0 5", ram_we, q_addr.size());
    end
    // Restart at addr 0, then abort together with the final accept.
    start_load(10'd2, 5'd1);
    feed(32'hC0);
    n_tests++; if (ram_addr !== 13'h0 || ram_we !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart got addr=%h we=%b want 0000 1", ram_addr, ram_we);
    end
    abort = 1'b1;
    feed(32'hC1);
    abort    = 1'b0;
    in_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 13'h1 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_final got we=%b addr=%h done=%b want 1 0001 0", ram_we, ram_addr, done);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
  endtask

  task automatic test_full();
    int bad;
    bad = 0;
    clear_mon();
    start_load(10'd512, 5'd16);
    for (int i = 0; i < 8192; i++) feed(32'(i));
    in_valid = 1'b0;
    n_tests++; if (done !== 1'b1 || ram_addr !== 13'h1FFF) begin
      n_fail++; $display("FAIL full_end got done=%b addr=%h want 1 1fff", done, ram_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (q_addr.size() != 8192) begin n_fail++; $display("FAIL full_count got %0d want 8192", q_addr.size()); end
    if (q_addr.size() == 8192) begin
      n_tests++; if (q_addr[511] !== 13'h01FF || q_addr[512] !== 13'h0200) begin
        n_fail++; $display("FAIL full_wrap got %h,%h want 01ff,0200", q_addr[511], q_addr[512]);
      end
      for (int i = 0; i < 8192; i++)
        if (q_addr[i] !== 13'(i) || q_data[i] !== 32'(i)) bad++;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL full_order got %0d bad writes want 0", bad); end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_async_reset();
    start_load(10'd4, 5'd2);
    for (int k = 0; k < 3; k++) feed(32'hE0 + 32'(k));
    // in_valid stays high; reset lands mid-cycle while ram_we is high.
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ram_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_now got we=%b busy=%b rdy=%b want 0 0 0", ram_we, busy, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL arst_idle got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    start_load(10'd4, 5'd2);
    feed(32'hF0);
    in_valid = 1'b0;
    n_tests++; if (ram_we !== 1'b1 || ram_addr !== 13'h0 || ram_data !== 32'hF0) begin
      n_fail++; $display("FAIL arst_reload got we=%b addr=%h data=%h want 1 0000 f0", ram_we, ram_addr, ram_data);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n              = 1'b0;
    start              = 1'b0;
    abort              = 1'b0;
    cfg_words_per_bank = '0;
    cfg_num_banks      = '0;
    in_valid           = 1'b0;
    in_data            = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_zero_cfg();
    test_abort();
    test_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
